// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrated mux and its single consumer.
interface rr_arb_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;

    // Arbiter side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux: round-robin or fixed-priority grant into one output register.
module rr_arb_mux #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N         = 4,
    parameter int unsigned FIXED_PRI = 0
) (
    input logic         clk,
    input logic         reset_n,
    rr_arb_mux_if.slave bus
);
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W = SEL_W + 1;

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [SEL_W-1:0] out_sel_q;
    logic [SEL_W-1:0] out_sel_d;

    logic [SEL_W-1:0] base_c;
    logic [N-1:0]     grant_c;
    logic [SEL_W-1:0] grant_idx_c;
    logic             grant_any_c;
    logic             load_en_c;
    logic [N-1:0]     in_ready_c;
    logic             xfer_c;

    // Search start: the rr pointer, or channel 0 when priority is fixed
    assign base_c = (FIXED_PRI != 0) ? '0 : ptr_q;

    // Rotate requests so the search start sits at bit 0, pick the lowest, rotate the index back
    always_comb begin
        logic [2*N-1:0]   dbl;
        logic [N-1:0]     rot;
        logic [IDX_W-1:0] sum;
        int               off;
        dbl         = {bus.in_valid, bus.in_valid} >> base_c;
        rot         = N'(dbl);
        grant_any_c = |rot;
        off         = 0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        sum = IDX_W'(base_c) + IDX_W'(off);
        if (sum >= IDX_W'(N)) begin
            sum = sum - IDX_W'(N);
        end
        grant_idx_c = SEL_W'(sum);
        grant_c     = '0;
        for (int i = 0; i < int'(N); i++) begin
            grant_c[i] = grant_any_c && (grant_idx_c == SEL_W'(i));
        end
    end

    // Register can take a word when empty or when its word leaves this cycle
    assign load_en_c  = ~out_valid_q | bus.out_ready;
    assign in_ready_c = grant_c & {N{load_en_c & reset_n}};
    assign xfer_c     = |in_ready_c;

    // Next state: load on transfer, drop valid on drain, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_sel_d   = grant_idx_c;
            for (int i = 0; i < int'(N); i++) begin
                if (grant_c[i]) begin
                    out_data_d = bus.in_data[i*WIDTH +: WIDTH];
                end
            end
            if (FIXED_PRI == 0) begin
                ptr_d = (grant_idx_c == SEL_W'(N - 1)) ? '0 : grant_idx_c + SEL_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and rr pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: round-robin, fixed-priority and single-channel instances.
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.WIDTH(32), .N(4)) if_rr ();
    rr_arb_mux_if #(.WIDTH(32), .N(4)) if_fp ();
    rr_arb_mux_if #(.WIDTH(8),  .N(1)) if_one ();

    rr_arb_mux #(.WIDTH(32), .N(4), .FIXED_PRI(0)) u_rr  (.clk(clk), .reset_n(reset_n), .bus(if_rr));
    rr_arb_mux #(.WIDTH(32), .N(4), .FIXED_PRI(1)) u_fp  (.clk(clk), .reset_n(reset_n), .bus(if_fp));
    rr_arb_mux #(.WIDTH(8),  .N(1), .FIXED_PRI(0)) u_one (.clk(clk), .reset_n(reset_n), .bus(if_one));

    task automatic test_reset();
        reset_n          = 1'b0;
        if_fp.in_valid   = '0;
        if_fp.in_data    = '0;
        if_fp.out_ready  = 1'b1;
        if_one.in_valid  = '0;
        if_one.in_data   = '0;
        if_one.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_rr.in_valid  = 4'($urandom);
            if_rr.in_data   = {$urandom, $urandom, $urandom, $urandom};
            if_rr.out_ready = 1'($urandom);
            repeat (2) @(negedge clk);
            #1;
            n_total++; if (if_rr.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_rr.out_valid); else n_pass++;
            n_total++; if (if_rr.out_data !== 32'h0) $display("FAIL reset_data got %h exp 0", if_rr.out_data); else n_pass++;
            n_total++; if (if_rr.out_sel !== 2'd0) $display("FAIL reset_sel got %0d exp 0", if_rr.out_sel); else n_pass++;
            n_total++; if (if_rr.in_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000 (valid %b)", if_rr.in_ready, if_rr.in_valid); else n_pass++;
        end
        if_rr.in_valid  = '0;
        if_rr.in_data   = '0;
        if_rr.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (if_rr.out_valid !== 1'b0) $display("FAIL post_reset_valid got %b exp 0", if_rr.out_valid); else n_pass++;
        n_total++; if (if_rr.out_data !== 32'h0) $display("FAIL post_reset_data got %h exp 0", if_rr.out_data); else n_pass++;
    endtask

    task automatic test_round_robin();
        int         exp_sel [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [3:0] exp_rdy;
        @(negedge clk);
        if_rr.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        if_rr.in_valid  = 4'b1111;
        if_rr.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = 4'b0001 << exp_sel[c];
            n_total++; if (if_rr.in_ready !== exp_rdy) $display("FAIL rr_ready c=%0d got %b exp %b", c, if_rr.in_ready, exp_rdy); else n_pass++;
            if (c > 0) begin
                n_total++; if (if_rr.out_sel !== 2'(exp_sel[c-1])) $display("FAIL rr_sel c=%0d got %0d exp %0d", c, if_rr.out_sel, exp_sel[c-1]); else n_pass++;
                n_total++; if (if_rr.out_data !== 32'hA0 + 32'(exp_sel[c-1])) $display("FAIL rr_data c=%0d got %h exp %h", c, if_rr.out_data, 32'hA0 + 32'(exp_sel[c-1])); else n_pass++;
            end
            @(negedge clk);
        end
        #1;
        n_total++; if (if_rr.out_sel !== 2'd3 || if_rr.out_data !== 32'hA3) $display("FAIL rr_last got sel %0d data %h exp 3 a3", if_rr.out_sel, if_rr.out_data); else n_pass++;
        if_rr.in_valid = 4'b0000;
        @(negedge clk);
        #1;
        n_total++; if (if_rr.out_valid !== 1'b0) $display("FAIL rr_drain got %b exp 0", if_rr.out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        if_rr.in_data   = {32'h0, 32'h1234, 32'h0B01, 32'h0B00};
        if_rr.in_valid  = 4'b0100;
        if_rr.out_ready = 1'b1;
        #1;
        n_total++; if (if_rr.in_ready !== 4'b0100) $display("FAIL bp_first_ready got %b exp 0100", if_rr.in_ready); else n_pass++;
        @(negedge clk);
        if_rr.in_valid  = 4'b0011;
        if_rr.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if (if_rr.out_valid !== 1'b1 || if_rr.out_data !== 32'h1234 || if_rr.out_sel !== 2'd2)
                $display("FAIL bp_hold c=%0d got v%b %h sel %0d exp v1 1234 sel 2", c, if_rr.out_valid, if_rr.out_data, if_rr.out_sel); else n_pass++;
            n_total++; if (if_rr.in_ready !== 4'b0000) $display("FAIL bp_stall_ready c=%0d got %b exp 0000", c, if_rr.in_ready); else n_pass++;
            @(negedge clk);
        end
        if_rr.out_ready = 1'b1;
        #1;
        n_total++; if (if_rr.in_ready !== 4'b0001) $display("FAIL bp_wrap_ready got %b exp 0001", if_rr.in_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (if_rr.out_sel !== 2'd0 || if_rr.out_data !== 32'h0B00 || if_rr.out_valid !== 1'b1)
            $display("FAIL bp_release got v%b %h sel %0d exp v1 0b00 sel 0", if_rr.out_valid, if_rr.out_data, if_rr.out_sel); else n_pass++;
        if_rr.in_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_drain();
        @(negedge clk);
        if_rr.in_data   = {32'hD3, 32'h0, 32'h0, 32'h0};
        if_rr.in_valid  = 4'b1000;
        if_rr.out_ready = 1'b1;
        #1;
        n_total++; if (if_rr.in_ready !== 4'b1000) $display("FAIL drain_ready got %b exp 1000", if_rr.in_ready); else n_pass++;
        @(negedge clk);
        if_rr.in_valid = 4'b0000;
        #1;
        n_total++; if (if_rr.out_valid !== 1'b1 || if_rr.out_data !== 32'hD3 || if_rr.out_sel !== 2'd3)
            $display("FAIL drain_word got v%b %h sel %0d exp v1 d3 sel 3", if_rr.out_valid, if_rr.out_data, if_rr.out_sel); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_total++; if (if_rr.out_valid !== 1'b0 || if_rr.out_data !== 32'hD3 || if_rr.out_sel !== 2'd3)
                $display("FAIL drain_idle c=%0d got v%b %h sel %0d exp v0 d3 sel 3", c, if_rr.out_valid, if_rr.out_data, if_rr.out_sel); else n_pass++;
        end
        if_rr.in_valid = 4'b1111;
        #1;
        n_total++; if (if_rr.in_ready !== 4'b0001) $display("FAIL drain_ptr got %b exp 0001", if_rr.in_ready); else n_pass++;
        if_rr.in_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if_rr.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        if_rr.in_valid  = 4'b1111;
        if_rr.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_total++; if (if_rr.out_valid !== 1'b1 || if_rr.in_ready !== 4'b0010)
            $display("FAIL mid_before got v%b ready %b exp v1 0010", if_rr.out_valid, if_rr.in_ready); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if (if_rr.out_valid !== 1'b0 || if_rr.out_data !== 32'h0 || if_rr.out_sel !== 2'd0)
            $display("FAIL mid_reset_out got v%b %h sel %0d exp v0 0 sel 0", if_rr.out_valid, if_rr.out_data, if_rr.out_sel); else n_pass++;
        n_total++; if (if_rr.in_ready !== 4'b0000) $display("FAIL mid_reset_ready got %b exp 0000", if_rr.in_ready); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_total++; if (if_rr.in_ready !== 4'b0001) $display("FAIL mid_first_grant got %b exp 0001", if_rr.in_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (if_rr.out_valid !== 1'b1 || if_rr.out_data !== 32'hA0 || if_rr.out_sel !== 2'd0)
            $display("FAIL mid_first_word got v%b %h sel %0d exp v1 a0 sel 0", if_rr.out_valid, if_rr.out_data, if_rr.out_sel); else n_pass++;
        if_rr.in_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        if_fp.in_data   = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        if_fp.in_valid  = 4'b1010;
        if_fp.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++; if (if_fp.in_ready !== 4'b0010) $display("FAIL fp_ready c=%0d got %b exp 0010", c, if_fp.in_ready); else n_pass++;
            if (c > 0) begin
                n_total++; if (if_fp.out_sel !== 2'd1 || if_fp.out_data !== 32'hF1)
                    $display("FAIL fp_word c=%0d got %h sel %0d exp f1 sel 1", c, if_fp.out_data, if_fp.out_sel); else n_pass++;
            end
            @(negedge clk);
        end
        if_fp.out_ready = 1'b0;
        #1;
        n_total++; if (if_fp.in_ready !== 4'b0000) $display("FAIL fp_stall got %b exp 0000", if_fp.in_ready); else n_pass++;
        if_fp.in_valid  = 4'b0000;
        if_fp.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_channel();
        @(negedge clk);
        if_one.in_valid  = 1'b1;
        if_one.in_data   = 8'h55;
        if_one.out_ready = 1'b1;
        #1;
        n_total++; if (if_one.in_ready !== 1'b1) $display("FAIL one_ready got %b exp 1", if_one.in_ready); else n_pass++;
        @(negedge clk);
        if_one.in_data   = 8'h66;
        if_one.out_ready = 1'b0;
        #1;
        n_total++; if (if_one.out_valid !== 1'b1 || if_one.out_data !== 8'h55 || if_one.out_sel !== 1'b0)
            $display("FAIL one_word got v%b %h sel %0d exp v1 55 sel 0", if_one.out_valid, if_one.out_data, if_one.out_sel); else n_pass++;
        n_total++; if (if_one.in_ready !== 1'b0) $display("FAIL one_stall got %b exp 0", if_one.in_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (if_one.out_data !== 8'h55) $display("FAIL one_hold got %h exp 55", if_one.out_data); else n_pass++;
        if_one.out_ready = 1'b1;
        #1;
        n_total++; if (if_one.in_ready !== 1'b1) $display("FAIL one_reload_ready got %b exp 1", if_one.in_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (if_one.out_valid !== 1'b1 || if_one.out_data !== 8'h66)
            $display("FAIL one_back_to_back got v%b %h exp v1 66", if_one.out_valid, if_one.out_data); else n_pass++;
        if_one.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_fixed_priority();
        test_single_channel();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_total);
        $fatal(1);
    end
endmodule
